// File: rtl/div16s_by_8u_if.sv
// div16s_by_8u_if: start/busy/done handshake and operand/result bus of the divider
interface div16s_by_8u_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic            start;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            busy;
    logic            done;
    logic [DW_N-1:0] quotient;
    logic [DW_D:0]   remainder;
    logic            div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div16s_by_8u.sv
// div16s_by_8u: iterative restoring divider, signed 16-bit dividend by unsigned 8-bit divisor
module div16s_by_8u #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input logic           clk,
    input logic           rst_n,
    div16s_by_8u_if.slave bus
);
    localparam int CW = $clog2(DW_N);
    localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DZ = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [DW_N-1:0] mag_q, mag_d, quotient_q, quotient_d;
    logic [DW_D:0]   part_q, part_d, remainder_q, remainder_d;
    logic [DW_D+1:0] trial;
    logic [DW_D-1:0] div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d, fits;

    // magnitude register shifts out dividend bits and shifts in quotient bits
    assign trial = {part_q, mag_q[DW_N-1]};
    assign fits  = trial >= {2'b00, div_q};

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        part_d      = part_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                neg_d = bus.dividend[DW_N-1];
                if (bus.divisor != '0) begin
                    mag_d   = bus.dividend[DW_N-1] ? -bus.dividend : bus.dividend;
                    div_d   = bus.divisor;
                    part_d  = '0;
                    cnt_d   = CW'(DW_N - 1);
                    state_d = S_CALC;
                end else begin
                    state_d = S_DZ;
                end
            end
            S_CALC: begin
                part_d  = fits ? (DW_D+1)'(trial - {2'b00, div_q}) : trial[DW_D:0];
                mag_d   = {mag_q[DW_N-2:0], fits};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                quotient_d  = neg_q ? -mag_q : mag_q;
                remainder_d = neg_q ? -part_q : part_q;
                div_zero_d  = 1'b0;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                quotient_d  = neg_q ? {1'b1, {(DW_N-1){1'b0}}} : {1'b0, {(DW_N-1){1'b1}}};
                remainder_d = '0;
                div_zero_d  = 1'b1;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mag_q       <= '0;
            part_q      <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            part_q      <= part_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div16s_by_8u.sv
// tb_div16s_by_8u: directed and randomized checks of div16s_by_8u against truncating-division arithmetic
module tb_div16s_by_8u;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    div16s_by_8u_if bus ();
    div16s_by_8u dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [15:0] TA [5] = '{16'h03E8, 16'hFC18, 16'h8000, 16'h8000, 16'h0000};
    localparam logic [7:0]  TB [5] = '{8'd7, 8'd7, 8'd255, 8'd1, 8'd200};
    localparam logic [15:0] TQ [5] = '{16'h008E, 16'hFF72, 16'hFF80, 16'h8000, 16'h0000};
    localparam logic [8:0]  TR [5] = '{9'h006, 9'h1FA, 9'h180, 9'h000, 9'h000};

    // Drives one start (callable mid-cycle, including in a done cycle), optionally pulses a
    // second start with junk operands 'inject' cycles after acceptance, and waits for done.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int inject,
                          output int lat, output logic busy0, output int bcnt);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        busy0 = bus.busy;
        bcnt  = int'(bus.busy);
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == inject) begin
                bus.start    = 1'b1;
                bus.dividend = 16'($urandom);
                bus.divisor  = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
                     bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat, bcnt;
        logic b0;
        for (int i = 0; i < 5; i++) begin
            run_op(TA[i], TB[i], 0, lat, b0, bcnt);
            n_chk += 5;
            if (lat !== 17) begin n_fail++; $display("FAIL dir%0d latency: got %0d expected 17", i, lat); end
            if (bcnt !== 17) begin n_fail++; $display("FAIL dir%0d busy cycles: got %0d expected 17", i, bcnt); end
            if (bus.quotient !== TQ[i]) begin n_fail++; $display("FAIL dir%0d quotient: got %h expected %h", i, bus.quotient, TQ[i]); end
            if (bus.remainder !== TR[i]) begin n_fail++; $display("FAIL dir%0d remainder: got %h expected %h", i, bus.remainder, TR[i]); end
            if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL dir%0d div_zero: got %b expected 0", i, bus.div_zero); end
            @(posedge clk); #1;
            n_chk += 2;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d done width: done=%b expected 0", i, bus.done); end
            if (bus.quotient !== TQ[i]) begin n_fail++; $display("FAIL dir%0d hold: got %h expected %h", i, bus.quotient, TQ[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        logic b0;
        run_op(16'd100, 8'd0, 0, lat, b0, bcnt);
        n_chk += 5;
        if (lat !== 1) begin n_fail++; $display("FAIL dz+ latency: got %0d expected 1", lat); end
        if (b0 !== 1'b0 || bcnt !== 0) begin n_fail++; $display("FAIL dz+ busy: got %b/%0d expected 0/0", b0, bcnt); end
        if (bus.quotient !== 16'h7FFF) begin n_fail++; $display("FAIL dz+ quotient: got %h expected 7fff", bus.quotient); end
        if (bus.remainder !== 9'h000) begin n_fail++; $display("FAIL dz+ remainder: got %h expected 000", bus.remainder); end
        if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz+ div_zero: got %b expected 1", bus.div_zero); end
        @(posedge clk); #1;
        run_op(16'hFFFB, 8'd0, 0, lat, b0, bcnt);
        n_chk += 3;
        if (lat !== 1) begin n_fail++; $display("FAIL dz- latency: got %0d expected 1", lat); end
        if (bus.quotient !== 16'h8000) begin n_fail++; $display("FAIL dz- quotient: got %h expected 8000", bus.quotient); end
        if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz- div_zero: got %b expected 1", bus.div_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic b0;
        run_op(16'd1000, 8'd7, 5, lat, b0, bcnt);
        n_chk += 3;
        if (lat !== 17) begin n_fail++; $display("FAIL ignore latency: got %0d expected 17", lat); end
        if (bus.quotient !== 16'd142) begin n_fail++; $display("FAIL ignore quotient: got %h expected 008e", bus.quotient); end
        if (bus.remainder !== 9'd6) begin n_fail++; $display("FAIL ignore remainder: got %h expected 006", bus.remainder); end
        run_op(16'd50, 8'd5, 0, lat, b0, bcnt);
        n_chk += 3;
        if (lat !== 17) begin n_fail++; $display("FAIL b2b latency: got %0d expected 17", lat); end
        if (bus.quotient !== 16'd10) begin n_fail++; $display("FAIL b2b quotient: got %h expected 000a", bus.quotient); end
        if (bus.remainder !== 9'd0) begin n_fail++; $display("FAIL b2b remainder: got %h expected 000", bus.remainder); end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, seen;
        logic b0;
        bus.dividend = 16'd1000; bus.divisor = 8'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder} !== 28'd0) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
                     bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        n_chk++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort quiet: got %0d active cycles expected 0", seen); end
        run_op(16'd50, 8'd5, 0, lat, b0, bcnt);
        n_chk += 2;
        if (lat !== 17) begin n_fail++; $display("FAIL post-abort latency: got %0d expected 17", lat); end
        if (bus.quotient !== 16'd10 || bus.remainder !== 9'd0) begin
            n_fail++; $display("FAIL post-abort result: got %h r %h expected 000a r 000", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, ai, bi, qe, re, qi, ri, sel, inj;
        logic [15:0] a;
        logic [7:0] b;
        logic b0;
        for (int n = 0; n < 2500; n++) begin
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'hFFFF :
                (sel == 3) ? 16'h0000 : 16'($urandom);
            sel = $urandom_range(0, 9);
            b = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd255 : 8'($urandom);
            inj = (b != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            ai = int'($signed(a));
            bi = int'(b);
            qe = (bi == 0) ? ((ai < 0) ? -32768 : 32767) : ai / bi;
            re = (bi == 0) ? 0 : ai % bi;
            run_op(a, b, inj, lat, b0, bcnt);
            qi = int'($signed(bus.quotient));
            ri = int'($signed(bus.remainder));
            n_chk += 4;
            if (lat !== ((bi == 0) ? 1 : 17)) begin n_fail++; $display("FAIL rnd latency %h/%h: got %0d", a, b, lat); end
            if (qi !== qe) begin n_fail++; $display("FAIL rnd quotient %h/%h: got %0d expected %0d", a, b, qi, qe); end
            if (ri !== re) begin n_fail++; $display("FAIL rnd remainder %h/%h: got %0d expected %0d", a, b, ri, re); end
            if (bus.div_zero !== (bi == 0)) begin n_fail++; $display("FAIL rnd div_zero %h/%h: got %b", a, b, bus.div_zero); end
            if (bi != 0) begin
                n_chk += 2;
                if (qi * bi + ri !== ai) begin n_fail++; $display("FAIL rnd identity %h/%h: got %0d expected %0d", a, b, qi * bi + ri, ai); end
                if ((ri < 0 ? -ri : ri) >= bi) begin n_fail++; $display("FAIL rnd rem bound %h/%h: got %0d", a, b, ri); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
